// File: rtl/hd_data_pattern_io.sv
// Data-pattern endpoint for the simulated drive. The checker compares host words
// against an incrementing sequence, and the generator offers an incrementing sequence.
module hd_data_pattern_io #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] START_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_enable,
  input  logic                   rd_stb,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_error,
  output logic [DATA_WIDTH-1:0]  rd_bad_data,
  output logic [COUNT_WIDTH-1:0] rd_count,
  input  logic                   wr_enable,
  input  logic                   wr_stb,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic [COUNT_WIDTH-1:0] wr_count
);

  // Handshake: each strobe is a one-cycle valid. The endpoint is always ready,
  // so every strobe seen while its path is enabled is a completed transfer.
  logic [DATA_WIDTH-1:0] expected;
  logic [DATA_WIDTH-1:0] generator;
  logic                  rd_enable_q;
  logic                  rd_rise;
  logic                  rd_mismatch;

  assign rd_rise     = rd_enable & ~rd_enable_q;
  assign rd_mismatch = rd_stb && (rd_data != expected);
  assign wr_data     = generator;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_enable_q <= 1'b0;
      expected    <= START_VALUE;
      rd_error    <= 1'b0;
      rd_bad_data <= '0;
      rd_count    <= '0;
    end else begin
      rd_enable_q <= rd_enable;
      if (!rd_enable) begin
        expected <= START_VALUE;
        rd_count <= '0;
      end else begin
        if (rd_rise) begin
          rd_error    <= 1'b0;
          rd_bad_data <= '0;
        end
        // On the session's first cycle the old error is being cleared, so a mismatch still counts as the first one.
        if (rd_mismatch && (!rd_error || rd_rise)) begin
          rd_error    <= 1'b1;
          rd_bad_data <= rd_data;
        end
        if (rd_stb) begin
          expected <= expected + 1'b1;
          rd_count <= rd_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      generator <= START_VALUE;
      wr_count  <= '0;
    end else if (!wr_enable) begin
      generator <= START_VALUE;
      wr_count  <= '0;
    end else if (wr_stb) begin
      generator <= generator + 1'b1;
      wr_count  <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_data_pattern_io.sv
// Directed bench for hd_data_pattern_io. Checks use immediate assertions, and a
// second instance is started near the all-ones value to exercise data wrap.
module tb_hd_data_pattern_io;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_enable = 1'b0, rd_stb = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_error;
  logic [31:0] rd_bad_data;
  logic [23:0] rd_count;
  logic        wr_enable = 1'b0, wr_stb = 1'b0;
  logic [31:0] wr_data;
  logic [23:0] wr_count;

  logic        w_rd_enable = 1'b0, w_rd_stb = 1'b0;
  logic [31:0] w_rd_data = '0;
  logic        w_rd_error;
  logic [31:0] w_rd_bad_data;
  logic [23:0] w_rd_count;
  logic        w_wr_enable = 1'b0, w_wr_stb = 1'b0;
  logic [31:0] w_wr_data;
  logic [23:0] w_wr_count;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [31:0] exp_q[$];

  hd_data_pattern_io dut (
    .clk(clk), .rst(rst),
    .rd_enable(rd_enable), .rd_stb(rd_stb), .rd_data(rd_data),
    .rd_error(rd_error), .rd_bad_data(rd_bad_data), .rd_count(rd_count),
    .wr_enable(wr_enable), .wr_stb(wr_stb), .wr_data(wr_data), .wr_count(wr_count)
  );

  hd_data_pattern_io #(.START_VALUE(32'hFFFF_FFFE)) dut_wrap (
    .clk(clk), .rst(rst),
    .rd_enable(w_rd_enable), .rd_stb(w_rd_stb), .rd_data(w_rd_data),
    .rd_error(w_rd_error), .rd_bad_data(w_rd_bad_data), .rd_count(w_rd_count),
    .wr_enable(w_wr_enable), .wr_stb(w_wr_stb), .wr_data(w_wr_data), .wr_count(w_wr_count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Advance one cycle and settle #1 after the edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic rd_word(input logic [31:0] d);
    rd_stb  = 1'b1;
    rd_data = d;
    tick();
    rd_stb  = 1'b0;
  endtask

  initial begin
    // Reset: two cycles of rst.
    rst = 1'b1;
    tick(); tick();
    check("reset_rd_error", {31'b0, rd_error}, 32'd0);
    check("reset_rd_count", {8'b0, rd_count}, 32'd0);
    check("reset_rd_bad", rd_bad_data, 32'd0);
    check("reset_wr_data", wr_data, 32'd0);
    check("reset_wr_count", {8'b0, wr_count}, 32'd0);
    check("reset_wrap_wr_data", w_wr_data, 32'hFFFF_FFFE);
    rst = 1'b0;
    tick();

    // Clean check: 0..15, with enable rising on the first strobe cycle.
    rd_enable = 1'b1;
    for (int i = 0; i < 16; i++) rd_word(i);
    check("clean_rd_error", {31'b0, rd_error}, 32'd0);
    check("clean_rd_count", {8'b0, rd_count}, 32'd16);

    // Bad word: 0,1,7,3,4 -- the error appears after the third strobe.
    rd_enable = 1'b0; tick();
    check("disabled_rd_count", {8'b0, rd_count}, 32'd0);
    rd_enable = 1'b1;
    rd_word(32'd0); rd_word(32'd1);
    check("bad_pre_error", {31'b0, rd_error}, 32'd0);
    rd_word(32'd7);
    check("bad_error_set", {31'b0, rd_error}, 32'd1);
    check("bad_data_7", rd_bad_data, 32'd7);
    rd_word(32'd3); rd_word(32'd4);
    check("bad_error_sticky", {31'b0, rd_error}, 32'd1);
    check("bad_data_first", rd_bad_data, 32'd7);
    check("bad_rd_count", {8'b0, rd_count}, 32'd5);
    rd_enable = 1'b0; tick();
    check("drop_error_holds", {31'b0, rd_error}, 32'd1);
    check("drop_bad_holds", rd_bad_data, 32'd7);
    rd_enable = 1'b1; tick();
    check("raise_error_clr", {31'b0, rd_error}, 32'd0);
    check("raise_bad_clr", rd_bad_data, 32'd0);

    // Mismatch on the rising-edge cycle: the set wins over the clear.
    rd_enable = 1'b0; tick();
    rd_enable = 1'b1; rd_word(32'd5);
    check("rise_set_error", {31'b0, rd_error}, 32'd1);
    check("rise_set_bad", rd_bad_data, 32'd5);
    check("rise_set_count", {8'b0, rd_count}, 32'd1);
    rd_enable = 1'b0; tick();

    // Generator: back-to-back strobes give 0..7.
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    wr_enable = 1'b1; wr_stb = 1'b1;
    while (exp_q.size() != 0) begin
      check("gen_seq", wr_data, exp_q.pop_front());
      tick();
    end
    wr_stb = 1'b0;
    check("gen_count", {8'b0, wr_count}, 32'd8);
    check("gen_next_word", wr_data, 32'd8);
    wr_enable = 1'b0; tick();
    check("gen_disable_data", wr_data, 32'd0);
    check("gen_disable_count", {8'b0, wr_count}, 32'd0);

    // Wrap on both paths, starting at FFFFFFFE.
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    w_wr_enable = 1'b1; w_rd_enable = 1'b1;
    w_wr_stb = 1'b1; w_rd_stb = 1'b1;
    while (exp_q.size() != 0) begin
      w_rd_data = exp_q[0];
      check("wrap_wr_data", w_wr_data, exp_q.pop_front());
      tick();
    end
    w_wr_stb = 1'b0; w_rd_stb = 1'b0;
    check("wrap_wr_after", w_wr_data, 32'd1);
    check("wrap_wr_count", {8'b0, w_wr_count}, 32'd3);
    check("wrap_rd_error", {31'b0, w_rd_error}, 32'd0);
    check("wrap_rd_count", {8'b0, w_rd_count}, 32'd3);

    // Strobes with enables low are ignored.
    rd_enable = 1'b0; wr_enable = 1'b0;
    rd_stb = 1'b1; wr_stb = 1'b1; rd_data = 32'd0;
    tick(); tick(); tick();
    rd_stb = 1'b0; wr_stb = 1'b0;
    check("dis_rd_count", {8'b0, rd_count}, 32'd0);
    check("dis_wr_count", {8'b0, wr_count}, 32'd0);
    check("dis_wr_data", wr_data, 32'd0);

    // Reset in the middle of active sessions.
    rd_enable = 1'b1; wr_enable = 1'b1; tick();
    wr_stb = 1'b1; rd_word(32'd9); rd_word(32'd9); wr_stb = 1'b0;
    check("mid_rd_error", {31'b0, rd_error}, 32'd1);
    check("mid_wr_count", {8'b0, wr_count}, 32'd2);
    check("mid_wr_data", wr_data, 32'd2);
    rst = 1'b1; tick();
    check("rst_rd_error", {31'b0, rd_error}, 32'd0);
    check("rst_rd_bad", rd_bad_data, 32'd0);
    check("rst_rd_count", {8'b0, rd_count}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_wr_count", {8'b0, wr_count}, 32'd0);
    check("rst_wrap_wr_data", w_wr_data, 32'hFFFF_FFFE);
    rst = 1'b0;
    tick();

    // Final report.
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
